// File: rtl/wireless_host.sv
// wireless_host: host-side initiator for the single-byte request/response
// bike-controller protocol. Polls heart rate, resolved angle and speed
// (codes 1-4) and pushes heart-cap / wheel-size config (codes 5/6 + value).
module wireless_host #(
    parameter int unsigned POLL_INTERVAL = 1_000_000,
    parameter int unsigned RESP_TIMEOUT  = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       transmit,
    output logic [7:0] tx_byte,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       is_transmitting,
    input  logic       recv_error,
    input  logic       cfg_req,
    input  logic       cfg_sel,
    input  logic [7:0] cfg_value,
    output logic [7:0] heartRate,
    output logic [9:0] resolvedAngle,
    output logic [7:0] speed,
    output logic       data_valid,
    output logic       timeout_err,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_ok
);

    localparam int unsigned PI_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int unsigned RT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [PI_W-1:0] POLL_LAST = PI_W'(POLL_INTERVAL - 1);
    localparam logic [RT_W-1:0] RESP_LAST = RT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        COMMIT
    } state_t;

    state_t state, state_d;

    // Transaction context: step is the poll step (0..3 -> codes 1..4)
    // or the config phase (0 = code byte, 1 = value byte).
    logic [1:0]      step;
    logic            is_cfg;
    logic            cfg_sel_q;
    logic [7:0]      cfg_val_q;
    logic [PI_W-1:0] poll_cnt;
    logic [RT_W-1:0] resp_cnt;

    // Shadow registers filled step by step during a poll.
    logic [7:0] sh_hr;
    logic [1:0] sh_sign;
    logic [7:0] sh_ang;
    logic [7:0] sh_spd;

    // Committed poll results.
    logic [7:0] hr_q;
    logic [9:0] ang_q;
    logic [7:0] spd_q;

    // Decoded control from the next-state logic.
    logic       start_cfg;
    logic       start_poll;
    logic       got_reply;
    logic       step_adv;
    logic       cfg_end;
    logic       cfg_end_ok;
    logic [7:0] cur_code;

    // Byte to send for the current step of the current transaction.
    always_comb begin
        cur_code = '0;
        if (is_cfg) begin
            if (step == 2'd0) cur_code = cfg_sel_q ? 8'd6 : 8'd5;
            else              cur_code = cfg_val_q;
        end else begin
            cur_code = 8'(step) + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state decode and pulse outputs.
    always_comb begin
        state_d     = state;
        transmit    = 1'b0;
        tx_byte     = '0;
        timeout_err = 1'b0;
        data_valid  = 1'b0;
        start_cfg   = 1'b0;
        start_poll  = 1'b0;
        got_reply   = 1'b0;
        step_adv    = 1'b0;
        cfg_end     = 1'b0;
        cfg_end_ok  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_req) begin
                    start_cfg = 1'b1;
                    state_d   = SEND;
                end else if (poll_cnt == POLL_LAST) begin
                    start_poll = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                tx_byte = cur_code;
                if (!is_transmitting) begin
                    transmit = 1'b1;
                    state_d  = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // Error beats a simultaneous reply; a reply beats the timeout.
                if (recv_error || (!received && resp_cnt == RESP_LAST)) begin
                    timeout_err = 1'b1;
                    cfg_end     = is_cfg;
                    state_d     = IDLE;
                end else if (received) begin
                    got_reply = 1'b1;
                    if (is_cfg) begin
                        if (step == 2'd0 && rx_byte == 8'd1) begin
                            step_adv = 1'b1;
                            state_d  = SEND;
                        end else begin
                            cfg_end    = 1'b1;
                            cfg_end_ok = (step != 2'd0) && (rx_byte == 8'd1);
                            state_d    = IDLE;
                        end
                    end else if (step == 2'd3) begin
                        state_d = COMMIT;
                    end else begin
                        step_adv = 1'b1;
                        state_d  = SEND;
                    end
                end
            end
            COMMIT: begin
                data_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Interval counter runs only while idling; cleared on every exit from IDLE
    // so each transaction end restarts the poll interval from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   poll_cnt <= '0;
        else if (state == IDLE && state_d == IDLE)    poll_cnt <= poll_cnt + 1'b1;
        else                                          poll_cnt <= '0;
    end

    // Reply timeout counter, zero on the first WAIT_RESP cycle after transmit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  resp_cnt <= '0;
        else if (state == WAIT_RESP) resp_cnt <= resp_cnt + 1'b1;
        else                         resp_cnt <= '0;
    end

    // Transaction context; config inputs are latched at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= '0;
            is_cfg    <= 1'b0;
            cfg_sel_q <= 1'b0;
            cfg_val_q <= '0;
        end else if (start_cfg) begin
            step      <= '0;
            is_cfg    <= 1'b1;
            cfg_sel_q <= cfg_sel;
            cfg_val_q <= cfg_value;
        end else if (start_poll) begin
            step   <= '0;
            is_cfg <= 1'b0;
        end else if (step_adv) begin
            step <= step + 2'd1;
        end
    end

    // Poll replies land in the shadow for the current step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hr   <= '0;
            sh_sign <= '0;
            sh_ang  <= '0;
            sh_spd  <= '0;
        end else if (got_reply && !is_cfg) begin
            case (step)
                2'd0:    sh_hr   <= rx_byte;
                2'd1:    sh_sign <= rx_byte[1:0];
                2'd2:    sh_ang  <= rx_byte;
                default: sh_spd  <= rx_byte;
            endcase
        end
    end

    // Committed results, copied from the shadows when leaving COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_q  <= '0;
            ang_q <= '0;
            spd_q <= '0;
        end else if (state == COMMIT) begin
            hr_q  <= sh_hr;
            ang_q <= {sh_sign, sh_ang};
            spd_q <= sh_spd;
        end
    end

    // The shadows are forwarded during COMMIT so the new values are already
    // on the outputs in the same cycle as the data_valid pulse.
    assign heartRate     = (state == COMMIT) ? sh_hr : hr_q;
    assign resolvedAngle = (state == COMMIT) ? {sh_sign, sh_ang} : ang_q;
    assign speed         = (state == COMMIT) ? sh_spd : spd_q;

    // Config status: busy from acceptance through the cycle of cfg_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
            cfg_ok   <= 1'b0;
        end else begin
            cfg_done <= cfg_end;
            if (cfg_end) cfg_ok <= cfg_end_ok;
            if (start_cfg)     cfg_busy <= 1'b1;
            else if (cfg_done) cfg_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wireless_host.sv
// tb_wireless_host: directed bench with a responder model for the controller
// side and scoreboard queues for transmitted bytes, poll results and config status.
module tb_wireless_host;

    localparam int PI = 200;
    localparam int RT = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_transmitting;
    logic       recv_error;
    logic       cfg_req;
    logic       cfg_sel;
    logic [7:0] cfg_value;
    logic [7:0] heartRate;
    logic [9:0] resolvedAngle;
    logic [7:0] speed;
    logic       data_valid;
    logic       timeout_err;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_ok;

    wireless_host #(.POLL_INTERVAL(PI), .RESP_TIMEOUT(RT)) dut (
        .clk(clk), .rst_n(rst_n),
        .transmit(transmit), .tx_byte(tx_byte),
        .received(received), .rx_byte(rx_byte),
        .is_transmitting(is_transmitting), .recv_error(recv_error),
        .cfg_req(cfg_req), .cfg_sel(cfg_sel), .cfg_value(cfg_value),
        .heartRate(heartRate), .resolvedAngle(resolvedAngle), .speed(speed),
        .data_valid(data_valid), .timeout_err(timeout_err),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_ok(cfg_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hr;
        logic [9:0] ang;
        logic [7:0] spd;
    } out_t;

    logic [7:0] exp_tx[$];
    out_t       exp_out[$];
    logic       exp_cfg[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int tx_count = 0, last_tx_cyc = 0;
    logic [7:0] last_tx_byte = '0;
    logic prev_tx = 1'b0;
    int dv_count = 0, to_count = 0, to_cyc = 0, cfg_count = 0;
    int last_rx_cyc = 0;

    // Responder configuration.
    logic [7:0] r_hr, r_sign, r_ang, r_spd, r_ack1, r_ack2;
    logic [7:0] silent_code = '0;
    logic [7:0] err_code = '0;
    int         resp_delay = 3;
    bit         armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Controller model: answers each request byte after resp_delay cycles.
    initial begin
        logic [7:0] b;
        logic [7:0] rep;
        forever begin
            @(negedge clk);
            if (rst_n && transmit) begin
                b = tx_byte;
                rep = '0;
                if (armed) begin
                    rep = r_ack2;
                    armed = 1'b0;
                end else begin
                    case (b)
                        8'd1: rep = r_hr;
                        8'd2: rep = r_sign;
                        8'd3: rep = r_ang;
                        8'd4: rep = r_spd;
                        8'd5, 8'd6: begin
                            rep = r_ack1;
                            armed = (r_ack1 == 8'd1);
                        end
                        default: rep = '0;
                    endcase
                end
                if (!(silent_code != 0 && b == silent_code)) begin
                    repeat (resp_delay) tick();
                    if (err_code != 0 && b == err_code) recv_error = 1'b1;
                    rx_byte = rep;
                    received = 1'b1;
                    last_rx_cyc = cyc;
                    tick();
                    received = 1'b0;
                    recv_error = 1'b0;
                end
            end
        end
    end

    // Transmit monitor against the expected byte queue.
    always @(negedge clk) begin
        if (rst_n && transmit) begin
            tx_count++;
            last_tx_cyc = cyc;
            last_tx_byte = tx_byte;
            check("tx_one_cycle", {31'd0, prev_tx}, 32'd0);
            checks++;
            assert (exp_tx.size() != 0) else begin
                failures++;
                $error("FAIL tx_unexpected observed=%0h expected=none", tx_byte);
            end
            if (exp_tx.size() != 0) check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_tx.pop_front()});
        end
        prev_tx = transmit;
    end

    // Poll result monitor.
    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            out_t e;
            dv_count++;
            check("dv_latency", cyc, last_rx_cyc + 1);
            checks++;
            assert (exp_out.size() != 0) else begin
                failures++;
                $error("FAIL dv_unexpected observed=%0h expected=none", heartRate);
            end
            if (exp_out.size() != 0) begin
                e = exp_out.pop_front();
                check("heartRate", {24'd0, heartRate}, {24'd0, e.hr});
                check("resolvedAngle", {22'd0, resolvedAngle}, {22'd0, e.ang});
                check("speed", {24'd0, speed}, {24'd0, e.spd});
            end
        end
    end

    // Timeout and config-completion monitor.
    always @(negedge clk) begin
        if (rst_n && timeout_err) begin
            to_count++;
            to_cyc = cyc;
        end
        if (rst_n && cfg_done) begin
            cfg_count++;
            check("cfg_busy_at_done", {31'd0, cfg_busy}, 32'd1);
            checks++;
            assert (exp_cfg.size() != 0) else begin
                failures++;
                $error("FAIL cfg_unexpected observed=%0h expected=none", cfg_ok);
            end
            if (exp_cfg.size() != 0) check("cfg_ok", {31'd0, cfg_ok}, {31'd0, exp_cfg.pop_front()});
        end
    end

    initial begin
        int n0;
        int t0;
        rst_n = 1'b0; received = 1'b0; rx_byte = '0; is_transmitting = 1'b0;
        recv_error = 1'b0; cfg_req = 1'b0; cfg_sel = 1'b0; cfg_value = '0;
        r_hr = 8'd72; r_sign = 8'h06; r_ang = 8'h5A; r_spd = 8'd30;
        r_ack1 = 8'd1; r_ack2 = 8'd1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_heartRate", {24'd0, heartRate}, 32'd0);
        check("rst_angle", {22'd0, resolvedAngle}, 32'd0);
        check("rst_speed", {24'd0, speed}, 32'd0);
        check("rst_transmit", {31'd0, transmit}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_cfg_busy", {31'd0, cfg_busy}, 32'd0);
        check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        check("rst_cfg_ok", {31'd0, cfg_ok}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Poll A: upper sign bits ignored.
        exp_tx.push_back(8'd1); exp_tx.push_back(8'd2); exp_tx.push_back(8'd3); exp_tx.push_back(8'd4);
        exp_out.push_back('{hr: 8'd72, ang: 10'h25A, spd: 8'd30});
        n0 = dv_count;
        for (int i = 0; i < 3000 && dv_count == n0; i++) tick();
        check("pollA_done", dv_count, n0 + 1);

        // Poll B: negative sign.
        r_hr = 8'd80; r_sign = 8'hFF; r_ang = 8'h00; r_spd = 8'd31;
        exp_tx.push_back(8'd1); exp_tx.push_back(8'd2); exp_tx.push_back(8'd3); exp_tx.push_back(8'd4);
        exp_out.push_back('{hr: 8'd80, ang: 10'h300, spd: 8'd31});
        n0 = dv_count;
        for (int i = 0; i < 3000 && dv_count == n0; i++) tick();
        check("pollB_done", dv_count, n0 + 1);

        // No reply to code 3.
        r_hr = 8'd90; r_sign = 8'h01; r_ang = 8'h11; r_spd = 8'd32;
        silent_code = 8'd3;
        exp_tx.push_back(8'd1); exp_tx.push_back(8'd2); exp_tx.push_back(8'd3);
        n0 = to_count;
        for (int i = 0; i < 3000 && to_count == n0; i++) tick();
        check("timeout_seen", to_count, n0 + 1);
        check("timeout_code", {24'd0, last_tx_byte}, 32'd3);
        check("timeout_latency", to_cyc - last_tx_cyc, RT);
        check("timeout_keep_hr", {24'd0, heartRate}, 32'd80);
        check("timeout_keep_angle", {22'd0, resolvedAngle}, 32'h300);
        check("timeout_keep_speed", {24'd0, speed}, 32'd31);

        // Next poll after the interval; replies arrive on the last allowed cycle.
        silent_code = '0;
        resp_delay = RT;
        exp_tx.push_back(8'd1); exp_tx.push_back(8'd2); exp_tx.push_back(8'd3); exp_tx.push_back(8'd4);
        exp_out.push_back('{hr: 8'd90, ang: 10'h111, spd: 8'd32});
        t0 = to_cyc;
        n0 = tx_count;
        for (int i = 0; i < 3000 && tx_count == n0; i++) tick();
        check("repoll_tx", tx_count, n0 + 1);
        check("repoll_interval", last_tx_cyc - t0, PI + 1);
        n0 = dv_count;
        for (int i = 0; i < 3000 && dv_count == n0; i++) tick();
        check("late_reply_done", dv_count, n0 + 1);
        resp_delay = 3;

        // Config: wheel size 26, acks 1,1.
        cfg_sel = 1'b1; cfg_value = 8'd26; cfg_req = 1'b1;
        exp_tx.push_back(8'd6); exp_tx.push_back(8'd26);
        exp_cfg.push_back(1'b1);
        @(negedge clk);
        check("cfg_busy_before", {31'd0, cfg_busy}, 32'd0);
        tick();
        @(negedge clk);
        check("cfg_busy_rise", {31'd0, cfg_busy}, 32'd1);
        tick();
        cfg_req = 1'b0;
        n0 = cfg_count;
        for (int i = 0; i < 2000 && cfg_count == n0; i++) tick();
        check("cfgA_done", cfg_count, n0 + 1);
        @(negedge clk);
        check("cfg_busy_fall", {31'd0, cfg_busy}, 32'd0);
        check("cfg_ok_held", {31'd0, cfg_ok}, 32'd1);

        // Config: heart cap, first ack rejected.
        tick();
        r_ack1 = 8'd0;
        cfg_sel = 1'b0; cfg_value = 8'd150; cfg_req = 1'b1;
        exp_tx.push_back(8'd5);
        exp_cfg.push_back(1'b0);
        tick();
        tick();
        cfg_req = 1'b0;
        n0 = cfg_count;
        for (int i = 0; i < 2000 && cfg_count == n0; i++) tick();
        check("cfgB_done", cfg_count, n0 + 1);

        // UART busy holds off the next request.
        tick();
        is_transmitting = 1'b1;
        r_hr = 8'd100; r_sign = 8'hFE; r_ang = 8'h00; r_spd = 8'd40;
        exp_tx.push_back(8'd1); exp_tx.push_back(8'd2); exp_tx.push_back(8'd3); exp_tx.push_back(8'd4);
        exp_out.push_back('{hr: 8'd100, ang: 10'h200, spd: 8'd40});
        n0 = tx_count;
        repeat (PI + 100) tick();
        check("busy_no_tx", tx_count, n0);
        is_transmitting = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 10 && tx_count == n0; i++) tick();
        check("busy_release_tx", tx_count, n0 + 1);
        check("busy_release_cyc", last_tx_cyc, t0);
        n0 = dv_count;
        for (int i = 0; i < 3000 && dv_count == n0; i++) tick();
        check("busy_poll_done", dv_count, n0 + 1);

        // Receive error (with a simultaneous byte) during step 2.
        err_code = 8'd2;
        r_hr = 8'd111;
        exp_tx.push_back(8'd1); exp_tx.push_back(8'd2);
        n0 = to_count;
        t0 = dv_count;
        for (int i = 0; i < 3000 && to_count == n0; i++) tick();
        check("rxerr_abort", to_count, n0 + 1);
        check("rxerr_no_dv", dv_count, t0);
        check("rxerr_keep_hr", {24'd0, heartRate}, 32'd100);
        check("rxerr_keep_angle", {22'd0, resolvedAngle}, 32'h200);
        check("rxerr_keep_speed", {24'd0, speed}, 32'd40);
        err_code = '0;

        // Reset in the middle of a poll.
        exp_tx.push_back(8'd1);
        n0 = tx_count;
        for (int i = 0; i < 3000 && tx_count == n0; i++) tick();
        check("midpoll_tx", tx_count, n0 + 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_heartRate", {24'd0, heartRate}, 32'd0);
        check("midrst_angle", {22'd0, resolvedAngle}, 32'd0);
        check("midrst_speed", {24'd0, speed}, 32'd0);
        check("midrst_transmit", {31'd0, transmit}, 32'd0);
        n0 = dv_count;
        t0 = to_count;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("midrst_no_dv", dv_count, n0);
        check("midrst_no_timeout", to_count, t0);

        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_out_drained", exp_out.size(), 0);
        check("exp_cfg_drained", exp_cfg.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
